gaus_window_buffer: RTL



---
 rtl/gaus_window_buffer_pkg.sv | 14 +
 rtl/gaus_beat_counter.sv | 57 +++++
 rtl/gaus_window_buffer.sv | 106 ++++++++++
 3 files changed

// File: rtl/gaus_window_buffer_pkg.sv
// gaus_buf_pkg: state encoding, default widths and tap-slice helper shared by the window buffer.
package gaus_buf_pkg;

    typedef enum logic [2:0] {S_IDLE, S_FILL, S_PRESENT, S_PAUSE, S_DONE} bufState_t;

    localparam int DefaultDataW = 64;
    localparam int DefaultAddrW = 24;

    // Bit offset of a tap inside the packed output bank.
    function automatic int tapLsb(input int tap, input int dataW);
        return tap * dataW;
    endfunction

endpackage

// File: rtl/gaus_beat_counter.sv
// gaus_beat_counter: beat, pause and pixel-address counters with window-close and frame-end flags.
module gaus_beat_counter #(
    parameter int BEATS      = 4,
    parameter int PAUSE      = 1,
    parameter int ADDR_W     = 24,
    parameter int START_ADDR = 0,
    parameter int END_ADDR   = 2097151
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         frameStart,
    input  logic                         fillEntry,
    input  logic                         accept,
    input  logic                         inPause,
    input  logic                         frameClear,
    output logic [$clog2(BEATS+1)-1:0]   beatCount,
    output logic [ADDR_W-1:0]            pixelAddr,
    output logic                         windowClose,
    output logic                         frameEnd,
    output logic                         pauseDone
);

    localparam int BW = $clog2(BEATS + 1);
    localparam int PW = PAUSE > 0 ? $clog2(PAUSE + 1) : 1;

    logic [PW-1:0] pauseCount;
    logic          atEnd;

    assign atEnd       = pixelAddr == ADDR_W'(END_ADDR);
    assign windowClose = accept && (beatCount == BW'(BEATS - 1) || atEnd);
    assign pauseDone   = int'(pauseCount) + 1 >= PAUSE;

    // The address saturates at END_ADDR; frameEnd remembers that the last word was taken.
    always_ff @(posedge clk) begin
        if (reset) begin
            beatCount  <= '0;
            pauseCount <= '0;
            pixelAddr  <= ADDR_W'(START_ADDR);
            frameEnd   <= 1'b0;
        end else begin
            if (fillEntry)
                beatCount <= '0;
            else if (accept)
                beatCount <= beatCount + 1'b1;
            pauseCount <= inPause ? pauseCount + 1'b1 : '0;
            if (frameStart || frameClear)
                pixelAddr <= ADDR_W'(START_ADDR);
            else if (accept && !atEnd)
                pixelAddr <= pixelAddr + 1'b1;
            if (frameStart)
                frameEnd <= 1'b0;
            else if (accept && atEnd)
                frameEnd <= 1'b1;
        end
    end

endmodule

// File: rtl/gaus_window_buffer.sv
// gaus_window_buffer: DEPTH-tap sliding pixel window snapshotted every BEATS words for the Gaussian kernel.
// Define GAUS_WINDOW_BUFFER_CLR_EN to zero the taps on every entry to FILL (non-overlapping windows).
module gaus_window_buffer
    import gaus_buf_pkg::*;
#(
    parameter int DATA_W     = DefaultDataW,
    parameter int DEPTH      = 4,
    parameter int BEATS      = 4,
    parameter int PAUSE      = 1,
    parameter int ADDR_W     = DefaultAddrW,
    parameter int START_ADDR = 0,
    parameter int END_ADDR   = 2097151
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         start,
    input  logic                         in_valid,
    input  logic [DATA_W-1:0]            in_data,
    output logic                         in_ready,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [DEPTH*DATA_W-1:0]      out_bank,
    output logic [$clog2(BEATS+1)-1:0]   out_beats,
    output logic [ADDR_W-1:0]            pixel_addr,
    output logic                         busy,
    output logic                         frame_done
);

    localparam int BW = $clog2(BEATS + 1);

    bufState_t         state, nextState;
    logic [DATA_W-1:0] taps    [DEPTH];
    logic [DATA_W-1:0] shifted [DEPTH];
    logic [BW-1:0]     beatCount;
    logic              accept, fillEntry, windowClose, frameEnd, pauseDone;

    assign in_ready   = state == S_FILL;
    assign out_valid  = state == S_PRESENT;
    assign busy       = state != S_IDLE;
    assign frame_done = state == S_DONE;
    assign accept     = in_valid && in_ready;
    assign fillEntry  = nextState == S_FILL && state != S_FILL;

    gaus_beat_counter #(
        .BEATS      (BEATS),
        .PAUSE      (PAUSE),
        .ADDR_W     (ADDR_W),
        .START_ADDR (START_ADDR),
        .END_ADDR   (END_ADDR)
    ) counters (
        .clk         (clk),
        .reset       (reset),
        .frameStart  (state == S_IDLE && start),
        .fillEntry   (fillEntry),
        .accept      (accept),
        .inPause     (state == S_PAUSE),
        .frameClear  (state == S_DONE),
        .beatCount   (beatCount),
        .pixelAddr   (pixel_addr),
        .windowClose (windowClose),
        .frameEnd    (frameEnd),
        .pauseDone   (pauseDone)
    );

    always_comb begin
        nextState = state;
        case (state)
            S_IDLE:    nextState = start ? S_FILL : S_IDLE;
            S_FILL:    nextState = windowClose ? S_PRESENT : S_FILL;
            S_PRESENT: nextState = !out_ready ? S_PRESENT : frameEnd ? S_DONE : PAUSE > 0 ? S_PAUSE : S_FILL;
            S_PAUSE:   nextState = pauseDone ? S_FILL : S_PAUSE;
            S_DONE:    nextState = S_IDLE;
            default:   nextState = S_IDLE;
        endcase
    end

    // Post-shift view of the window, so the closing word lands in the snapshot.
    always_comb begin
        shifted[0] = in_data;
        for (int k = 1; k < DEPTH; k++)
            shifted[k] = taps[k-1];
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= S_IDLE;
            taps      <= '{default: '0};
            out_bank  <= '0;
            out_beats <= '0;
        end else begin
            state <= nextState;
            if (accept)
                taps <= shifted;
`ifdef GAUS_WINDOW_BUFFER_CLR_EN
            else if (fillEntry)
                taps <= '{default: '0};
`endif
            if (windowClose) begin
                for (int k = 0; k < DEPTH; k++)
                    out_bank[tapLsb(k, DATA_W) +: DATA_W] <= shifted[k];
                out_beats <= beatCount + 1'b1;
            end
        end
    end

endmodule
